// File: rtl/exc_tracker_pkg.sv
// Shared definitions for the exception tracker: exception codes, address
// defaults, the per-stage pipeline record and the code-merge rule.
package exc_tracker_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO_DEF      = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI_DEF      = 32'h0000_6ffc;

  typedef struct packed {
    logic        valid;
    logic [4:0]  code;
    logic [31:0] pc;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '{valid: 1'b0, code: 5'd0, pc: 32'd0};

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HANDLER = 1'b1
  } hstate_t;

  // The oldest detected exception wins; a stage's own code only fills a gap.
  function automatic logic [4:0] merge_code(input logic [4:0] carried,
                                            input logic [4:0] own);
    return (carried != EXC_INT) ? carried : own;
  endfunction

endpackage

// File: rtl/exc_tracker_if.sv
// Datapath/CP0-facing signal bundle of the exception tracker.
interface exc_tracker_if;
  logic        stall;
  logic [31:0] pc_f;
  logic [4:0]  exc_d;
  logic [4:0]  exc_e;
  logic [4:0]  exc_m;
  logic        eret_d;
  logic        req;
  logic [31:0] epc;
  logic [4:0]  exc_code_m;
  logic [31:0] vpc_m;
  logic        flush_all;
  logic        flush_fd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        in_handler;

  modport master (
    output stall, pc_f, exc_d, exc_e, exc_m, eret_d, req, epc,
    input  exc_code_m, vpc_m, flush_all, flush_fd, redirect, redirect_pc, in_handler
  );

  modport slave (
    input  stall, pc_f, exc_d, exc_e, exc_m, eret_d, req, epc,
    output exc_code_m, vpc_m, flush_all, flush_fd, redirect, redirect_pc, in_handler
  );
endinterface

// File: rtl/exc_tracker_stage_reg.sv
// One pipeline register carrying {valid, code, pc}; priority is
// clear > hold > bubble > load-with-merge.
module exc_stage_reg
  import exc_tracker_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       hold_i,
  input  logic       bubble_i,
  input  stage_t     in_i,
  input  logic [4:0] det_i,
  output stage_t     out_o
);

  stage_t rec_q;
  stage_t rec_d;

  // Next-record selection; an invalid upstream slot never picks up a code.
  always_comb begin
    rec_d = rec_q;
    if (clear_i) begin
      rec_d = STAGE_EMPTY;
    end else if (hold_i) begin
      rec_d = rec_q;
    end else if (bubble_i) begin
      rec_d = STAGE_EMPTY;
    end else if (in_i.valid) begin
      rec_d.valid = 1'b1;
      rec_d.code  = merge_code(in_i.code, det_i);
      rec_d.pc    = in_i.pc;
    end else begin
      rec_d = STAGE_EMPTY;
    end
  end

  // Record register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_q <= STAGE_EMPTY;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign out_o = rec_q;

endmodule

// File: rtl/exc_tracker.sv
// Exception tracker: fetch-address check, per-stage code carry to M, and
// flush/redirect generation for exception entry and eret.
module exc_tracker
  import exc_tracker_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter logic [31:0] TEXT_LO      = TEXT_LO_DEF,
  parameter logic [31:0] TEXT_HI      = TEXT_HI_DEF
) (
  input logic         clk,
  input logic         reset,
  exc_tracker_if.slave bus
);

  logic [4:0] exc_f_s;
  logic       eret_act_s;
  stage_t     fd_in_s;
  stage_t     fd_q;
  stage_t     de_q;
  stage_t     em_q;
  hstate_t    state_q;
  hstate_t    state_d;

  // Fetch address check: misaligned or outside the text segment is AdEL.
  always_comb begin
    exc_f_s = EXC_INT;
    if ((bus.pc_f[1:0] != 2'b00) || (bus.pc_f < TEXT_LO) || (bus.pc_f > TEXT_HI)) begin
      exc_f_s = EXC_ADEL;
    end else begin
      exc_f_s = EXC_INT;
    end
  end

  // eret only takes effect when it is not stalled and not overridden by req.
  assign eret_act_s = bus.eret_d & ~bus.stall & ~bus.req;
  assign fd_in_s    = '{valid: 1'b1, code: EXC_INT, pc: bus.pc_f};

  exc_stage_reg u_fd (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (bus.req | eret_act_s),
    .hold_i   (bus.stall),
    .bubble_i (1'b0),
    .in_i     (fd_in_s),
    .det_i    (exc_f_s),
    .out_o    (fd_q)
  );

  exc_stage_reg u_de (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (bus.req),
    .hold_i   (1'b0),
    .bubble_i (bus.stall),
    .in_i     (fd_q),
    .det_i    (bus.exc_d),
    .out_o    (de_q)
  );

  exc_stage_reg u_em (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (bus.req),
    .hold_i   (1'b0),
    .bubble_i (1'b0),
    .in_i     (de_q),
    .det_i    (bus.exc_e),
    .out_o    (em_q)
  );

  // Handler-state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handler-state transitions; a req inside the handler keeps it there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) state_d = ST_HANDLER;
        else         state_d = ST_IDLE;
      end
      ST_HANDLER: begin
        if (bus.req)         state_d = ST_HANDLER;
        else if (eret_act_s) state_d = ST_IDLE;
        else                 state_d = ST_HANDLER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.exc_code_m  = em_q.valid ? merge_code(em_q.code, bus.exc_m) : EXC_INT;
  assign bus.vpc_m       = em_q.pc;
  assign bus.flush_all   = bus.req;
  assign bus.flush_fd    = eret_act_s;
  assign bus.redirect    = bus.req | eret_act_s;
  assign bus.redirect_pc = bus.req ? HANDLER_ADDR : (eret_act_s ? bus.epc : 32'd0);
  assign bus.in_handler  = (state_q == ST_HANDLER);

endmodule
